logic_element_cfg: RTL

Parametrised successor to the fixed 4-input logic pair: a K-input LUT logic element with a serially loaded configuration chain, a mode-selectable fast-carry stage, and a clock-enabled output register with a combinational/registered output select. Configuration is shifted in over a daisy-chainable serial port rather than driven in parallel, so a CLB column can be programmed from one bitstream pin. It is the basic cell instantiated by the next-generation CLB.

---
 rtl/logic_element_cfg_pkg.sv | 29 ++
 rtl/logic_element_cfg_if.sv | 22 ++
 rtl/logic_element_cfg_chain.sv | 33 +++
 rtl/logic_element_cfg.sv | 65 ++++++
 4 files changed

// File: rtl/logic_element_cfg_pkg.sv
// Shared definitions for the configurable K-input logic element.
package le_pkg;

  // Full configuration word: 2^K truth-table bits + out_sel + carry_sel.
  function automatic int cfg_width(input int k);
    return (1 << k) + 2;
  endfunction

  // Position of out_sel in the configuration word.
  function automatic int out_sel_idx(input int k);
    return 1 << k;
  endfunction

  // Position of carry_sel in the configuration word.
  function automatic int carry_sel_idx(input int k);
    return (1 << k) + 1;
  endfunction

  // Indices for the default 4-input cell.
  localparam int K_DEFAULT     = 4;
  localparam int OUT_SEL_IDX   = out_sel_idx(K_DEFAULT);
  localparam int CARRY_SEL_IDX = carry_sel_idx(K_DEFAULT);

  typedef enum logic {
    MODE_LOGIC = 1'b0,
    MODE_CARRY = 1'b1
  } carry_mode_e;

endpackage

// File: rtl/logic_element_cfg_if.sv
// Cell-level signal bundle: LUT inputs, carry chain, serial config port, output.
interface logic_element_cfg_if #(parameter int K = 4);
  logic [K-1:0] x;
  logic         carry_in;
  logic         cfg_en;
  logic         cfg_in;
  logic         cfg_out;
  logic         cfg_done;
  logic         ce;
  logic         out;
  logic         carry_out;

  modport master (
    output x, carry_in, cfg_en, cfg_in, ce,
    input  cfg_out, cfg_done, out, carry_out
  );

  modport slave (
    input  x, carry_in, cfg_en, cfg_in, ce,
    output cfg_out, cfg_done, out, carry_out
  );
endinterface

// File: rtl/logic_element_cfg_chain.sv
// Serial configuration shift register with a saturating load counter.
// The first bit shifted in ends in sr[0]; sr[0] also feeds the next cell.
module cfg_shift_chain #(
  parameter int CFG_W = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_in,
  output logic [CFG_W-1:0] sr,
  output logic             cfg_out,
  output logic             cfg_done
);
  localparam int              CNT_W   = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

  logic [CNT_W-1:0] cnt;

  // Shift on enable; the counter stops at CFG_W so extra shifts (daisy chain
  // pass-through) keep cfg_done asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (cfg_en) begin
      sr <= {cfg_in, sr[CFG_W-1:1]};
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign cfg_out  = sr[0];
  assign cfg_done = (cnt == CNT_MAX);
endmodule

// File: rtl/logic_element_cfg.sv
// K-input LUT logic element: serial config chain, optional fast-carry stage,
// clock-enabled output register and comb/registered output select.
module logic_element_cfg
  import le_pkg::*;
#(
  parameter int K = 4
) (
  input  logic                clk,
  input  logic                reset,
  logic_element_cfg_if.slave  bus
);
  localparam int CFG_W = cfg_width(K);
  localparam int LUT_N = 1 << K;
  localparam int OSEL  = out_sel_idx(K);
  localparam int CSEL  = carry_sel_idx(K);

  logic [CFG_W-1:0] sr;
  logic [LUT_N-1:0] lut;
  logic             out_sel;
  carry_mode_e      mode;
  logic             f;
  logic             sum;
  logic             q;

  cfg_shift_chain #(.CFG_W(CFG_W)) u_chain (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (bus.cfg_en),
    .cfg_in   (bus.cfg_in),
    .sr       (sr),
    .cfg_out  (bus.cfg_out),
    .cfg_done (bus.cfg_done)
  );

  assign lut     = sr[LUT_N-1:0];
  assign out_sel = sr[OSEL];
  assign mode    = carry_mode_e'(sr[CSEL]);

  // LUT lookup and carry stage; while configuring, the partially loaded
  // word must not leak, so out is held low and carry passes straight through.
  always_comb begin
    f             = lut[bus.x];
    sum           = f;
    bus.carry_out = bus.carry_in;
    if (mode == MODE_CARRY) begin
      sum           = f ^ bus.carry_in;
      bus.carry_out = f ? bus.carry_in : bus.x[K-1];
    end
    if (bus.cfg_en) begin
      bus.out       = 1'b0;
      bus.carry_out = bus.carry_in;
    end else begin
      bus.out = out_sel ? q : sum;
    end
  end

  // Output register: captures sum on enabled edges, frozen during config.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (bus.ce && !bus.cfg_en) begin
      q <= sum;
    end
  end
endmodule
